pca_mean_center: RTL and testbench

//  Streaming mean-centering stage feeding the PCA covariance datapath on the PYNQ-Z2 build.
//  - Accepts a batch of N samples of D signed features each, and buffers the whole batch internally.
//  - Computes the per-feature mean, then re-streams every element with its feature mean subtracted.
//  - Sits directly upstream of the covariance accumulator; its output stream is that block's input.

---
 rtl/pca_mean_center.sv | 145 ++++++++++++++
 tb/tb_pca_mean_center.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pca_mean_center.sv
// Streaming mean-centering stage: buffers one batch of N samples x D features, computes
// per-feature means, then re-streams every element minus its feature mean.
module pca_mean_center #(
    parameter int DATA_W       = 16,
    parameter int NUM_FEAT     = 4,
    parameter int LOG2_SAMPLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W:0]   m_data,
    output logic              m_last,
    output logic              busy
);

    localparam int NUM_SAMP = 1 << LOG2_SAMPLES;
    localparam int DEPTH    = NUM_FEAT * NUM_SAMP;
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int FEAT_W   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int SUM_W    = DATA_W + LOG2_SAMPLES;
    localparam int OUT_W    = DATA_W + 1;

    localparam logic [FEAT_W-1:0] FEAT_LAST = FEAT_W'(NUM_FEAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_MEAN,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic        [DATA_W-1:0] mem_q [DEPTH];
    logic signed [SUM_W-1:0]  sum_q [NUM_FEAT];
    logic signed [DATA_W-1:0] mean_q [NUM_FEAT];
    logic signed [DATA_W-1:0] mean_c [NUM_FEAT];

    logic [ADDR_W-1:0] wr_addr_q;
    logic [FEAT_W-1:0] wr_feat_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [FEAT_W-1:0] rd_feat_q;

    logic             m_valid_q;
    logic             m_last_q;
    logic [OUT_W-1:0] m_data_q;

    logic                     accept;
    logic                     out_fire;
    logic                     load_out;
    logic signed [DATA_W-1:0] cur_mean;
    logic        [OUT_W-1:0]  diff;

    assign s_ready  = (state_q == S_LOAD);
    assign busy     = (state_q != S_LOAD);
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_data   = m_data_q;

    assign accept   = s_ready && s_valid;
    assign out_fire = m_valid_q && m_ready;
    // The output register is refilled in MEAN (first beat) and on every non-final transfer,
    // so a held-high m_ready sees one element per cycle with no bubble.
    assign load_out = (state_q == S_MEAN) ||
                      ((state_q == S_DRAIN) && out_fire && !m_last_q);

    always_comb begin
        for (int unsigned f = 0; f < NUM_FEAT; f++) begin
            mean_c[f] = DATA_W'(sum_q[f] >>> LOG2_SAMPLES);
        end
    end

    // In MEAN the mean registers are not yet loaded, so the first beat uses the live value.
    assign cur_mean = (state_q == S_MEAN) ? mean_c[rd_feat_q] : mean_q[rd_feat_q];
    assign diff     = OUT_W'($signed(mem_q[rd_addr_q])) - OUT_W'(cur_mean);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (accept && (wr_addr_q == ADDR_LAST)) state_d = S_MEAN;
            S_MEAN:  state_d = S_DRAIN;
            S_DRAIN: if (out_fire && m_last_q) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_addr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LOAD;
            wr_addr_q <= '0;
            wr_feat_q <= '0;
            rd_addr_q <= '0;
            rd_feat_q <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            for (int unsigned f = 0; f < NUM_FEAT; f++) begin
                sum_q[f]  <= '0;
                mean_q[f] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (accept) begin
                sum_q[wr_feat_q] <= sum_q[wr_feat_q] + SUM_W'($signed(s_data));
                wr_addr_q        <= (wr_addr_q == ADDR_LAST) ? '0 : wr_addr_q + 1'b1;
                wr_feat_q        <= (wr_feat_q == FEAT_LAST) ? '0 : wr_feat_q + 1'b1;
            end

            if (state_q == S_MEAN) begin
                for (int unsigned f = 0; f < NUM_FEAT; f++) begin
                    mean_q[f] <= mean_c[f];
                end
            end

            if (load_out) begin
                m_valid_q <= 1'b1;
                m_data_q  <= diff;
                m_last_q  <= (rd_addr_q == ADDR_LAST);
                rd_addr_q <= rd_addr_q + 1'b1;
                rd_feat_q <= (rd_feat_q == FEAT_LAST) ? '0 : rd_feat_q + 1'b1;
            end else if (out_fire) begin
                // Final transfer of the batch: release the output and clear for the next batch.
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                rd_addr_q <= '0;
                rd_feat_q <= '0;
                for (int unsigned f = 0; f < NUM_FEAT; f++) begin
                    sum_q[f] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pca_mean_center.sv
// Self-checking bench for pca_mean_center (D=4, N=8, DATA_W=16) using an expected-value
// scoreboard filled by a reference model when each batch is driven.
module tb_pca_mean_center;

    localparam int D   = 4;
    localparam int TOT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [16:0] m_data;
    logic        m_last;
    logic        busy;

    typedef struct packed {
        logic [16:0] data;
        logic        last;
    } exp_t;

    typedef logic signed [15:0] batch_t [TOT];

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   ready_pct = 100;

    logic        prev_stall = 1'b0;
    logic [16:0] prev_data;
    logic        prev_last;

    pca_mean_center #(
        .DATA_W      (16),
        .NUM_FEAT    (4),
        .LOG2_SAMPLES(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_last (m_last),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference model: floor mean per feature, exact 17-bit difference.
    function automatic void push_expected(input batch_t x);
        int   sum [D];
        int   mean;
        exp_t e;
        for (int f = 0; f < D; f++) sum[f] = 0;
        for (int i = 0; i < TOT; i++) sum[i % D] += int'(x[i]);
        for (int i = 0; i < TOT; i++) begin
            mean   = sum[i % D] >>> 3;
            e.data = 17'(int'(x[i]) - mean);
            e.last = (i == TOT - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Output scoreboard and stall-stability monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total_cnt++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last)
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                else pass_cnt++;
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_output: got d=%h l=%b, want no output", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.data || m_last !== e.last)
                        $display("FAIL scoreboard: got d=%h l=%b, want d=%h l=%b",
                                 m_data, m_last, e.data, e.last);
                    else pass_cnt++;
                end
            end
            prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(99) < 32'(ready_pct));
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    task automatic send_batch(input batch_t x, input int gap_pct);
        int waited;
        push_expected(x);
        for (int i = 0; i < TOT; i++) begin
            while ($urandom_range(99) < 32'(gap_pct)) begin
                s_valid = 1'b0;
                s_data  = 16'($urandom);
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = x[i];
            waited  = 0;
            @(negedge clk);
            while (s_ready !== 1'b1 && waited < 400) begin
                @(negedge clk);
                waited++;
            end
            if (s_ready !== 1'b1) begin
                total_cnt++;
                $display("FAIL accept_timeout: got s_ready=%b, want 1", s_ready);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end else begin
            @(posedge clk);
            #1;
            if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL after_drain: got rdy=%b v=%b busy=%b, want 1 0 0", s_ready, m_valid, busy);
            else pass_cnt++;
        end
    endtask

    function automatic batch_t uniform_batch();
        batch_t x;
        for (int i = 0; i < TOT; i++) x[i] = 16'(10 * ((i % D) + 1));
        return x;
    endfunction

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b, want 1", s_ready); else pass_cnt++;
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b, want 0", m_valid); else pass_cnt++;
        total_cnt++;
        if (m_last !== 1'b0) $display("FAIL reset_m_last: got %b, want 0", m_last); else pass_cnt++;
        total_cnt++;
        if (m_data !== 17'h0) $display("FAIL reset_m_data: got %h, want 0", m_data); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", busy); else pass_cnt++;
    endtask

    task automatic test_uniform();
        ready_pct = 100;
        @(posedge clk); #1;
        send_batch(uniform_batch(), 0);
        total_cnt++;
        if (m_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL latency_early: got v=%b busy=%b, want v=0 busy=1", m_valid, busy);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (m_valid !== 1'b1) $display("FAIL latency_first: got v=%b, want 1", m_valid); else pass_cnt++;
        wait_drain();
    endtask

    task automatic test_ramp();
        batch_t x;
        for (int i = 0; i < TOT; i++) x[i] = (i % D == 0) ? 16'(i / D) : 16'sd0;
        send_batch(x, 0);
        wait_drain();
    endtask

    task automatic test_floor();
        batch_t x;
        for (int i = 0; i < TOT; i++) x[i] = (i % D == 1) ? (((i / D) % 2 == 0) ? -16'sd1 : 16'sd0) : 16'sd0;
        send_batch(x, 0);
        wait_drain();
    endtask

    task automatic test_extreme();
        batch_t x;
        for (int i = 0; i < TOT; i++)
            x[i] = (i % D == 2) ? (((i / D) % 2 == 0) ? 16'sh8000 : 16'sh7FFF) : 16'sd0;
        send_batch(x, 0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        batch_t x;
        ready_pct = 50;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < TOT; i++) x[i] = 16'($urandom);
            send_batch(x, 30);
        end
        wait_drain();
        ready_pct = 100;
    endtask

    task automatic test_reset_mid_drain();
        int n = 0;
        ready_pct = 100;
        @(posedge clk); #1;
        send_batch(uniform_batch(), 0);
        while (exp_q.size() > TOT - 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0)
            $display("FAIL midreset_outputs: got v=%b busy=%b l=%b, want 0 0 0", m_valid, busy, m_last);
        else pass_cnt++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL midreset_release: got rdy=%b v=%b, want 1 0", s_ready, m_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        send_batch(uniform_batch(), 0);
        wait_drain();
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        test_reset();
        test_uniform();
        test_ramp();
        test_floor();
        test_extreme();
        test_back_to_back();
        test_reset_mid_drain();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
